// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x3 keypad scanner.
// Holds the FSM state enum, keypad geometry and the map-index-to-key-code helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } keypad_state_e;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int MAP_W    = NUM_ROWS * NUM_COLS;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Map bit index is row*3+col. Rows 0..2 carry digits 1..9 in reading order;
  // the bottom row is '*', '0', '#'.
  function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd9:    code = KEY_STAR;
      4'd10:   code = 4'd0;
      4'd11:   code = KEY_HASH;
      default: code = (idx < 4'd9) ? idx + 4'd1 : 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_frame_decode.sv
// keypad_frame_decode: combinational decode of one 12-bit scan frame into a
// saturated pressed-key count (0, 1, 2 meaning "two or more") and the code of
// the lowest-indexed pressed key.
module keypad_frame_decode
  import keypad_pkg::*;
(
  input  logic [MAP_W-1:0] map_i,
  output logic [1:0]       n_o,
  output logic [3:0]       code_o
);

  logic found;

  // Walk the map from index 0 upward; the first set bit supplies the code and
  // the count stops growing once it reaches 2.
  always_comb begin
    n_o    = 2'd0;
    code_o = 4'd0;
    found  = 1'b0;
    for (int i = 0; i < MAP_W; i++) begin
      if (map_i[i]) begin
        if (!found) begin
          code_o = idx_to_code(4'(i));
        end
        found = 1'b1;
        if (n_o != 2'd2) begin
          n_o = n_o + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row-scan sequencer and debounced key-event generator for
// the 4x3 door-lock keypad. One row is driven per dwell of SCAN_DIV cycles, the
// synchronized columns are sampled at the end of each dwell, and every 4-row
// frame is decoded and fed to a press/release debounce FSM.
// Optional feature macro: KEYPAD_REPEAT_EN adds auto-repeat key_valid pulses
// every REPEAT_SCANS frames while the accepted key stays the only key pressed.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       init,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       scan_err
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  // Refuse to elaborate with parameter values the scanner cannot honour.
  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scan_ctrl: SCAN_DIV must be >= 4, DEBOUNCE_SCANS and REPEAT_SCANS >= 1");
  end

  logic [2:0]       col_meta_q, col_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_idx_q;
  logic [3:0]       row_q;
  logic [MAP_W-1:0] map_q, map_d;
  logic [MAP_W-1:0] frame_map;
  logic             tc, frame_end;
  logic [1:0]       n_w;
  logic [3:0]       code_w;
  logic             single_key, no_key;

  keypad_state_e    state_q;
  logic [3:0]       cand_q;
  logic [DB_W-1:0]  deb_cnt_q, rel_cnt_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q, key_held_q, scan_err_q;

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (init) begin
      col_meta_q <= '0;
      col_sync_q <= '0;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  // Next dwell count and frame map: store the current row's sample at terminal
  // count, or clear the map when the frame completes.
  always_comb begin
    tc        = (cnt_q == CNT_LAST);
    frame_end = tc && (row_idx_q == 2'd3);
    cnt_d     = tc ? '0 : cnt_q + 1'b1;
    map_d     = map_q;
    if (frame_end) begin
      map_d = '0;
    end else if (tc) begin
      map_d[row_idx_q*NUM_COLS +: NUM_COLS] = col_sync_q;
    end
  end

  // The decoder sees the stored rows 0..2 plus the live bottom-row sample, so the
  // frame is complete on the very cycle it ends.
  assign frame_map = {col_sync_q, map_q[3*NUM_COLS-1:0]};

  keypad_frame_decode u_decode (
    .map_i  (frame_map),
    .n_o    (n_w),
    .code_o (code_w)
  );

  assign single_key = (n_w == 2'd1);
  assign no_key     = (n_w == 2'd0);

  // Dwell counter, row rotation and frame map storage.
  always_ff @(posedge clk) begin
    if (init) begin
      cnt_q     <= '0;
      row_idx_q <= 2'd0;
      row_q     <= 4'b0001;
      map_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      map_q <= map_d;
      if (tc) begin
        row_idx_q <= row_idx_q + 2'd1;
        row_q     <= {row_q[2:0], row_q[3]};
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_SCANS);
  logic [REP_W-1:0] rep_cnt_q;
`endif

  // Debounce FSM with registered key outputs; only frame ends move it.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      scan_err_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      scan_err_q  <= 1'b0;
      if (frame_end) begin
        scan_err_q <= (n_w == 2'd2);
        case (state_q)
          IDLE: begin
            if (single_key) begin
              cand_q <= code_w;
              if (DEBOUNCE_SCANS == 1) begin
                key_code_q  <= code_w;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state_q     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_q   <= '0;
`endif
              end else begin
                deb_cnt_q <= DB_W'(1);
                state_q   <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (!single_key) begin
              state_q <= IDLE;
            end else if (code_w != cand_q) begin
              cand_q    <= code_w;
              deb_cnt_q <= DB_W'(1);
            end else if (deb_cnt_q + 1'b1 == DB_TARGET) begin
              key_code_q  <= cand_q;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              state_q     <= HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_q   <= '0;
`endif
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end
          HELD: begin
            if (no_key) begin
              if (DEBOUNCE_SCANS == 1) begin
                key_held_q <= 1'b0;
                state_q    <= IDLE;
              end else begin
                rel_cnt_q <= DB_W'(1);
                state_q   <= RELEASE;
              end
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_q <= '0;
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              if (single_key && code_w == key_code_q) begin
                if (rep_cnt_q + 1'b1 == REP_TARGET) begin
                  key_valid_q <= 1'b1;
                  rep_cnt_q   <= '0;
                end else begin
                  rep_cnt_q <= rep_cnt_q + 1'b1;
                end
              end else begin
                rep_cnt_q <= '0;
              end
`endif
            end
          end
          RELEASE: begin
            if (no_key) begin
              if (rel_cnt_q + 1'b1 == DB_TARGET) begin
                key_held_q <= 1'b0;
                state_q    <= IDLE;
              end else begin
                rel_cnt_q <= rel_cnt_q + 1'b1;
              end
            end else begin
              state_q <= HELD;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q <= '0;
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign scan_err  = scan_err_q;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Row-scan sequencer and key-event generator for the 4x3 door-lock keypad. It drives one keypad row at a time and samples the three column lines at the end of each row dwell. Each full 4-row frame is decoded into a single key, and a key is accepted only after it has been stable across a set number of frames. The block sits between the keypad pins and the safe FSM and replaces free-running row rotation with debounced, one-cycle key events.

## Interface
Parameters:
- SCAN_DIV, 1000000: clock cycles per row dwell; minimum 4.
- DEBOUNCE_SCANS, 4: number of consecutive identical frames needed to accept a press, and number of consecutive empty frames needed to accept a release; minimum 1.
- REPEAT_SCANS, 50: frames between auto-repeat events (used only when the repeat macro is defined).

Ports:
- clk  in  1  system clock.
- init  in  1  reset; synchronous, active-high.
- col  in  3  raw column lines; col[0] is the left column; high means the key is pressed.
- row  out  4  one-hot row drive; row[0] is the top row.
- key_code  out  4  accepted key: 0–9 are digits, 10 is `*`, 11 is `#`.
- key_valid  out  1  one-cycle pulse when a key is accepted.
- key_held  out  1  level; high from acceptance until release is accepted.
- scan_err  out  1  one-cycle pulse when a frame contains more than one pressed key.

## Operation
- col passes through a 2-flop synchronizer before use.
- Dwell counter counts 0..SCAN_DIV-1. At terminal count:
  - the synced col is written into a 12-bit frame map at bit row_idx*3+c;
  - row rotates 0001→0010→0100→1000→0001.
- Frame end is the terminal count of row 3 (row=1000). At frame end:
  - the map is decoded into a pressed-key count n and a key code;
  - the map is then cleared.
- Key map by row: row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = `*`,0,`#`.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. Transitions are evaluated only at frame end.
  - IDLE:
    - n==1 → load the candidate, set deb_cnt=1, go to DEBOUNCE.
    - If DEBOUNCE_SCANS==1, accept immediately and go to HELD.
  - DEBOUNCE:
    - Same single key → deb_cnt+1. When deb_cnt reaches DEBOUNCE_SCANS: accept the key and go to HELD.
    - Different single key → reload the candidate, set deb_cnt=1.
    - n==0 or n>1 → go to IDLE.
  - HELD:
    - n==0 → set rel_cnt=1, go to RELEASE. If DEBOUNCE_SCANS==1, go to IDLE instead.
    - Any nonempty frame → stay in HELD.
  - RELEASE:
    - n==0 → rel_cnt+1. When rel_cnt reaches DEBOUNCE_SCANS: go to IDLE and clear key_held.
    - Nonempty frame → go back to HELD.
- Accepting a key means, on the same clock edge:
  - key_code ← candidate;
  - key_valid ← 1 for one cycle;
  - key_held ← 1.
- scan_err pulses at every frame with n>1, in any state.
- key_code holds its value until the next acceptance.

## Timing
- Reset values: row=0001, key_code=0, key_valid=0, key_held=0, scan_err=0. FSM goes to IDLE; counters and map are zeroed.
- Reset mid-dwell or mid-debounce discards the partial frame and the candidate. No key_valid is issued.
- Frame length is 4*SCAN_DIV cycles.
- key_valid and scan_err are registered. They assert the cycle after the frame-end terminal-count cycle.
- Minimum press-to-key_valid latency is DEBOUNCE_SCANS frames plus 1 cycle, plus up to one frame of alignment and 2 synchronizer cycles.
- Row changes on the cycle after terminal count. The sample taken at terminal count always belongs to the row driven during that dwell.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - HELD counts frames in which the accepted key is the only key pressed.
  - When the count reaches REPEAT_SCANS, key_valid pulses again with an unchanged key_code, and the count restarts.
  - Any other frame resets the count.
- KEYPAD_REPEAT_EN undefined: exactly one key_valid per press, and no repeat counter is present.

## Structure
- keypad_pkg:
  - state enum (IDLE, DEBOUNCE, HELD, RELEASE);
  - constants KEY_STAR=10 and KEY_HASH=11;
  - constant NUM_ROWS=4 and NUM_COLS=3;
  - map-index-to-code function.
- Sub-module keypad_frame_decode: combinational. Takes the 12-bit map; outputs n saturated to 2 bits (0, 1, ≥2) and the 4-bit code of the lowest set bit.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3.
- Reset: init high 2 cycles, then low → row=0001, all outputs 0; row advances every 4 cycles, sequence 0001,0010,0100,1000,0001.
- Press '5' (col=010 while row=0010) for 4 frames → exactly one key_valid, key_code=5, key_held=1, one cycle after the 2nd qualifying frame end.
- Bounce: '5' present 1 frame, then absent 2 frames → no key_valid, key_held stays 0.
- '1' and '9' held together for 3 frames → scan_err pulses 3 times, key_valid never asserts.
- After '5' accepted: release → key_held falls after 2 empty frames; then press '#' → key_valid with key_code=11.
- init asserted during DEBOUNCE → row=0001 next cycle, no key_valid. With KEYPAD_REPEAT_EN, hold '0' for 8 frames → key_valid at acceptance and again at 3 and 6 frames after acceptance, key_code=0.
